// File: rtl/plab5_mcore_dma_req_arbiter_pkg.sv
// Shared definitions for the DMA request arbiter: FSM encodings, memory-message
// control widths and the flattened-bus slice helper.
package plab5_mcore_dma_req_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Memory request/response message widths with the data payload removed
  localparam int MEM_REQ_CNBITS  = 45;
  localparam int MEM_RESP_CNBITS = 13;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/plab5_mcore_dma_req_arbiter_if.sv
// Requester-side and DMA-side handshake bundle; slave is the arbiter's view,
// master is the surrounding requesters plus DMA checker.
interface plab5_mcore_dma_req_arbiter_if
  import plab5_mcore_dma_req_arbiter_pkg::*;
#(
  parameter int p_num_reqs    = 4,
  parameter int p_addr_nbits  = 32,
  parameter int p_req_cnbits  = MEM_REQ_CNBITS,
  parameter int p_resp_cnbits = MEM_RESP_CNBITS
);

  logic [p_num_reqs-1:0]              req_val;
  logic [p_num_reqs-1:0]              req_rdy;
  logic [p_num_reqs-1:0]              req_domain;
  logic [p_num_reqs*p_addr_nbits-1:0] req_src_addr;
  logic [p_num_reqs*p_addr_nbits-1:0] req_dest_addr;
  logic [p_num_reqs*p_req_cnbits-1:0] req_control;

  logic [p_num_reqs-1:0]              resp_val;
  logic [p_num_reqs-1:0]              resp_rdy;
  logic [p_resp_cnbits-1:0]           resp_control;
  logic                               resp_domain;
  logic                               resp_err;

  logic                               dma_val;
  logic                               dma_rdy;
  logic                               dma_domain;
  logic [p_addr_nbits-1:0]            dma_src_addr;
  logic [p_addr_nbits-1:0]            dma_dest_addr;
  logic [p_req_cnbits-1:0]            dma_req_control;
  logic                               dma_ack;
  logic [p_resp_cnbits-1:0]           dma_resp_control;

  modport slave (
    input  req_val, req_domain, req_src_addr, req_dest_addr, req_control,
    input  resp_rdy, dma_rdy, dma_ack, dma_resp_control,
    output req_rdy, resp_val, resp_control, resp_domain, resp_err,
    output dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_req_control
  );

  modport master (
    output req_val, req_domain, req_src_addr, req_dest_addr, req_control,
    output resp_rdy, dma_rdy, dma_ack, dma_resp_control,
    input  req_rdy, resp_val, resp_control, resp_domain, resp_err,
    input  dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_req_control
  );

endinterface

// File: rtl/plab5_mcore_dma_req_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first valid requester
// found scanning upward (mod N) from rr_ptr; zero when nothing is valid.
module plab5_mcore_rr_pick #(
  parameter int p_num_reqs  = 4,
  parameter int p_ptr_nbits = $clog2(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0]  req_val,
  input  logic [p_ptr_nbits-1:0] rr_ptr,
  output logic [p_num_reqs-1:0]  grant
);

  logic                   found;
  logic [p_ptr_nbits-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      idx = p_ptr_nbits'((int'(rr_ptr) + i) % p_num_reqs);
      if (!found && req_val[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plab5_mcore_dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA command port; min 3 cycles accept-to-resp.
// dma_* held until dma_rdy, resp_* held until resp_rdy[grant]; one command in flight.
module plab5_mcore_dma_req_arbiter
  import plab5_mcore_dma_req_arbiter_pkg::*;
#(
  parameter int p_num_reqs    = 4,
  parameter int p_addr_nbits  = 32,
  parameter int p_req_cnbits  = MEM_REQ_CNBITS,
  parameter int p_resp_cnbits = MEM_RESP_CNBITS,
  parameter int p_timeout     = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  plab5_mcore_dma_req_arbiter_if.slave  bus,
  output logic                          busy
);

  localparam int PW = $clog2(p_num_reqs);
  localparam int TW = $clog2(p_timeout);

  typedef struct packed {
    logic                    domain;
    logic [p_addr_nbits-1:0] src_addr;
    logic [p_addr_nbits-1:0] dest_addr;
    logic [p_req_cnbits-1:0] control;
  } cmd_t;

  logic [1:0]               state_q, state_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            grant_q, grant_d;
  logic [TW-1:0]            timer_q, timer_d;
  cmd_t                     cmd_q, cmd_d;
  logic [p_resp_cnbits-1:0] resp_control_q, resp_control_d;
  logic                     resp_err_q, resp_err_d;

  logic [p_num_reqs-1:0]    pick;
  logic [PW-1:0]            win_idx;
  cmd_t                     win_cmd;

  plab5_mcore_rr_pick #(
    .p_num_reqs  (p_num_reqs),
    .p_ptr_nbits (PW)
  ) u_rr_pick (
    .req_val (bus.req_val),
    .rr_ptr  (rr_ptr_q),
    .grant   (pick)
  );

  always_comb begin
    win_idx = '0;
    win_cmd = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (pick[i]) begin
        win_idx           = PW'(i);
        win_cmd.domain    = bus.req_domain[i];
        win_cmd.src_addr  = bus.req_src_addr[slice_lo(i, p_addr_nbits) +: p_addr_nbits];
        win_cmd.dest_addr = bus.req_dest_addr[slice_lo(i, p_addr_nbits) +: p_addr_nbits];
        win_cmd.control   = bus.req_control[slice_lo(i, p_req_cnbits) +: p_req_cnbits];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    timer_d        = timer_q;
    cmd_d          = cmd_q;
    resp_control_d = resp_control_q;
    resp_err_d     = resp_err_q;
    case (state_q)
      IDLE: begin
        if (|pick) begin
          cmd_d   = win_cmd;
          grant_d = win_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dma_rdy) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // An ack landing on the final timeout cycle still counts as success
        if (bus.dma_ack) begin
          resp_control_d = bus.dma_resp_control;
          resp_err_d     = 1'b0;
          state_d        = RESP;
        end else if (timer_q == TW'(p_timeout - 1)) begin
          resp_control_d = '0;
          resp_err_d     = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (bus.resp_rdy[grant_q]) begin
          rr_ptr_d = (grant_q == PW'(p_num_reqs - 1)) ? '0 : grant_q + PW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      timer_q        <= '0;
      cmd_q          <= '0;
      resp_control_q <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      timer_q        <= timer_d;
      cmd_q          <= cmd_d;
      resp_control_q <= resp_control_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign bus.req_rdy         = (state_q == IDLE) ? pick : '0;
  assign bus.dma_val         = (state_q == ISSUE);
  assign bus.dma_domain      = cmd_q.domain;
  assign bus.dma_src_addr    = cmd_q.src_addr;
  assign bus.dma_dest_addr   = cmd_q.dest_addr;
  assign bus.dma_req_control = cmd_q.control;
  assign bus.resp_val        = (state_q == RESP) ? (p_num_reqs'(1) << grant_q) : '0;
  assign bus.resp_control    = resp_control_q;
  assign bus.resp_domain     = cmd_q.domain;
  assign bus.resp_err        = resp_err_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_plab5_mcore_dma_req_arbiter.sv
// Directed bench for the DMA request arbiter with hand-computed expectations.
module tb_plab5_mcore_dma_req_arbiter;

  logic clk;
  logic reset;
  logic busy;
  int   vectors;
  int   miscompares;

  plab5_mcore_dma_req_arbiter_if #(
    .p_num_reqs(4), .p_addr_nbits(32), .p_req_cnbits(45), .p_resp_cnbits(13)
  ) bus ();

  plab5_mcore_dma_req_arbiter #(
    .p_num_reqs(4), .p_addr_nbits(32), .p_req_cnbits(45), .p_resp_cnbits(13),
    .p_timeout(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic dom, input logic [31:0] src,
                         input logic [31:0] dst, input logic [44:0] ctl);
    bus.req_domain[i]            = dom;
    bus.req_src_addr[i*32 +: 32] = src;
    bus.req_dest_addr[i*32 +: 32] = dst;
    bus.req_control[i*45 +: 45]  = ctl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, bus.req_rdy, bus.dma_val, bus.resp_val, bus.resp_err} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want %b",
               {busy, bus.req_rdy, bus.dma_val, bus.resp_val, bus.resp_err}, 11'b0);
    end
    vectors++;
    if ({bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.resp_control} !== 122'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0",
               {bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.resp_control});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(2, 1'b1, 32'h100, 32'h200, 45'h1234_5678);
    bus.req_val = 4'b0100;
    #1;
    vectors++;
    if (bus.req_rdy !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_rdy: got %b want %b", bus.req_rdy, 4'b0100);
    end
    tick();
    bus.req_val = 4'b0000;
    #1;
    vectors++;
    if ({bus.dma_val, bus.dma_domain, bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, busy}
        !== {1'b1, 1'b1, 32'h100, 32'h200, 45'h1234_5678, 1'b1}) begin
      miscompares++;
      $display("FAIL single_dma: got %h/%h/%h dom %b val %b",
               bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.dma_domain, bus.dma_val);
    end
    bus.dma_rdy = 1'b1;
    tick();
    bus.dma_rdy = 1'b0;
    tick();
    bus.dma_ack          = 1'b1;
    bus.dma_resp_control = 13'h123;
    tick();
    bus.dma_ack = 1'b0;
    vectors++;
    if ({bus.resp_val, bus.resp_err, bus.resp_control, bus.resp_domain}
        !== {4'b0100, 1'b0, 13'h123, 1'b1}) begin
      miscompares++;
      $display("FAIL single_resp: got val %b err %b ctl %h dom %b want 0100 0 123 1",
               bus.resp_val, bus.resp_err, bus.resp_control, bus.resp_domain);
    end
    bus.resp_rdy = 4'b0100;
    tick();
    bus.resp_rdy = 4'b0000;
    vectors++;
    if ({bus.resp_val, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL single_done: got val %b busy %b want 0000 0", bus.resp_val, busy);
    end
    bus.req_val = 4'b1011;
    #1;
    vectors++;
    if (bus.req_rdy !== 4'b1000) begin
      miscompares++;
      $display("FAIL single_rrptr: got %b want %b", bus.req_rdy, 4'b1000);
    end
    bus.req_val = 4'b0000;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_oh;
    do_reset();
    for (int i = 0; i < 4; i++)
      set_req(i, i[0], 32'h1000 + i, 32'h2000 + i, 45'(i));
    bus.req_val = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      #1;
      vectors++;
      if (bus.req_rdy !== exp_oh) begin
        miscompares++;
        $display("FAIL fair_grant%0d: got %b want %b", k, bus.req_rdy, exp_oh);
      end
      tick();
      vectors++;
      if (bus.dma_src_addr !== 32'h1000 + 32'(k % 4)) begin
        miscompares++;
        $display("FAIL fair_src%0d: got %h want %h", k, bus.dma_src_addr, 32'h1000 + 32'(k % 4));
      end
      bus.dma_rdy = 1'b1;
      tick();
      bus.dma_rdy          = 1'b0;
      bus.dma_ack          = 1'b1;
      bus.dma_resp_control = 13'h40 + 13'(k);
      tick();
      bus.dma_ack = 1'b0;
      vectors++;
      if ({bus.resp_val, bus.req_rdy} !== {exp_oh, 4'b0000}) begin
        miscompares++;
        $display("FAIL fair_resp%0d: got val %b rdy %b want %b 0000", k, bus.resp_val, bus.req_rdy, exp_oh);
      end
      bus.resp_rdy = 4'b1111;
      tick();
      bus.resp_rdy = 4'b0000;
    end
    bus.req_val = 4'b0000;
  endtask

  task automatic test_timeout();
    set_req(1, 1'b0, 32'hAB, 32'hCD, 45'h5);
    bus.req_val = 4'b0010;
    tick();
    bus.req_val = 4'b0000;
    bus.dma_rdy = 1'b1;
    tick();
    bus.dma_rdy = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      vectors++;
      if ({bus.resp_val, busy} !== 5'b00001) begin
        miscompares++;
        $display("FAIL timeout_wait%0d: got val %b busy %b want 0000 1", c, bus.resp_val, busy);
      end
    end
    tick();
    vectors++;
    if ({bus.resp_val, bus.resp_err, bus.resp_control} !== {4'b0010, 1'b1, 13'h0}) begin
      miscompares++;
      $display("FAIL timeout_resp: got val %b err %b ctl %h want 0010 1 000",
               bus.resp_val, bus.resp_err, bus.resp_control);
    end
    bus.dma_ack          = 1'b1;
    bus.dma_resp_control = 13'h1FF;
    tick();
    bus.dma_ack = 1'b0;
    vectors++;
    if ({bus.resp_val, bus.resp_err, bus.resp_control} !== {4'b0010, 1'b1, 13'h0}) begin
      miscompares++;
      $display("FAIL timeout_lateack: got val %b err %b ctl %h want 0010 1 000",
               bus.resp_val, bus.resp_err, bus.resp_control);
    end
    bus.resp_rdy = 4'b0010;
    tick();
    bus.resp_rdy = 4'b0000;
    tick();
    vectors++;
    if ({bus.resp_val, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL timeout_noresp2: got val %b busy %b want 0000 0", bus.resp_val, busy);
    end
  endtask

  task automatic test_backpressure();
    set_req(3, 1'b0, 32'hAAAA_0003, 32'h5555_0003, 45'h1F_0000_0003);
    bus.req_val = 4'b1000;
    #1;
    vectors++;
    if (bus.req_rdy !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_grant: got %b want %b", bus.req_rdy, 4'b1000);
    end
    tick();
    bus.req_val = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.dma_rdy = 1'b1;
      #1;
      vectors++;
      if ({bus.dma_val, bus.dma_domain, bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.req_rdy}
          !== {1'b1, 1'b0, 32'hAAAA_0003, 32'h5555_0003, 45'h1F_0000_0003, 4'b0000}) begin
        miscompares++;
        $display("FAIL bp_issue%0d: got val %b src %h dst %h ctl %h rdy %b", c, bus.dma_val,
                 bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.req_rdy);
      end
      tick();
    end
    bus.dma_rdy          = 1'b0;
    bus.dma_ack          = 1'b1;
    bus.dma_resp_control = 13'h077;
    tick();
    bus.dma_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.resp_rdy = (c == 3) ? 4'b0111 : 4'b0000;
      #1;
      vectors++;
      if ({bus.resp_val, bus.req_rdy, bus.resp_control} !== {4'b1000, 4'b0000, 13'h077}) begin
        miscompares++;
        $display("FAIL bp_resp%0d: got val %b rdy %b ctl %h want 1000 0000 077",
                 c, bus.resp_val, bus.req_rdy, bus.resp_control);
      end
      tick();
    end
    bus.resp_rdy = 4'b1000;
    tick();
    bus.resp_rdy = 4'b0000;
    vectors++;
    if ({busy, bus.resp_val, bus.req_rdy} !== {1'b0, 4'b0000, 4'b0001}) begin
      miscompares++;
      $display("FAIL bp_release: got busy %b val %b rdy %b want 0 0000 0001", busy, bus.resp_val, bus.req_rdy);
    end
    bus.req_val = 4'b0000;
  endtask

  task automatic test_reset_mid_wait();
    set_req(1, 1'b1, 32'h3000, 32'h4000, 45'h9);
    bus.req_val = 4'b0010;
    tick();
    bus.req_val = 4'b0000;
    bus.dma_rdy = 1'b1;
    tick();
    bus.dma_rdy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({busy, bus.dma_val, bus.resp_val, bus.resp_err, bus.resp_domain, bus.dma_domain, bus.req_rdy} !== 13'b0) begin
      miscompares++;
      $display("FAIL rstmid_ctl: got busy %b dval %b rval %b err %b", busy, bus.dma_val, bus.resp_val, bus.resp_err);
    end
    vectors++;
    if ({bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.resp_control} !== 122'b0) begin
      miscompares++;
      $display("FAIL rstmid_data: got %h want 0",
               {bus.dma_src_addr, bus.dma_dest_addr, bus.dma_req_control, bus.resp_control});
    end
    bus.dma_ack          = 1'b1;
    bus.dma_resp_control = 13'h155;
    tick();
    bus.dma_ack = 1'b0;
    vectors++;
    if ({busy, bus.resp_val, bus.resp_control} !== 18'b0) begin
      miscompares++;
      $display("FAIL rstmid_ack: got busy %b val %b ctl %h want 0 0000 000", busy, bus.resp_val, bus.resp_control);
    end
    bus.req_val = 4'b1111;
    #1;
    vectors++;
    if (bus.req_rdy !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_rrptr: got %b want %b", bus.req_rdy, 4'b0001);
    end
    bus.req_val = 4'b0000;
  endtask

  task automatic test_ack_timeout_tie();
    set_req(0, 1'b0, 32'h10, 32'h20, 45'h3);
    bus.req_val = 4'b0001;
    tick();
    bus.req_val = 4'b0000;
    bus.dma_rdy = 1'b1;
    tick();
    bus.dma_rdy = 1'b0;
    repeat (7) tick();
    vectors++;
    if (bus.resp_val !== 4'b0000) begin
      miscompares++;
      $display("FAIL tie_prewait: got %b want %b", bus.resp_val, 4'b0000);
    end
    bus.dma_ack          = 1'b1;
    bus.dma_resp_control = 13'h0A5;
    tick();
    bus.dma_ack = 1'b0;
    vectors++;
    if ({bus.resp_val, bus.resp_err, bus.resp_control} !== {4'b0001, 1'b0, 13'h0A5}) begin
      miscompares++;
      $display("FAIL tie_resp: got val %b err %b ctl %h want 0001 0 0a5",
               bus.resp_val, bus.resp_err, bus.resp_control);
    end
    bus.resp_rdy = 4'b0001;
    tick();
    bus.resp_rdy = 4'b0000;
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    reset                = 1'b1;
    bus.req_val          = '0;
    bus.req_domain       = '0;
    bus.req_src_addr     = '0;
    bus.req_dest_addr    = '0;
    bus.req_control      = '0;
    bus.resp_rdy         = '0;
    bus.dma_rdy          = 1'b0;
    bus.dma_ack          = 1'b0;
    bus.dma_resp_control = '0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_ack_timeout_tie();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
